// File: rtl/multicycle_control_unit_if.sv
// Memory handshake between the multi-cycle controller and the unified instruction/data memory.
interface multicycle_control_unit_if;
  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (output mem_req, output mem_we, input mem_ready);
  modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle datapath sequencer: fetch/decode/execute/memory/write-back for the
// eight-opcode ISA, with a retired-instruction counter.
module multicycle_control_unit #(
  parameter int CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        halt,
  input  logic [2:0]                  opcode,
  input  logic                        zero,
  input  logic                        lt,
  multicycle_control_unit_if.master   bus,
  output logic                        iord,
  output logic                        ir_write,
  output logic                        pc_write,
  output logic                        pc_src,
  output logic [1:0]                  alu_op,
  output logic [1:0]                  alu_src_b,
  output logic                        reg_write,
  output logic                        reg_dst,
  output logic                        mem_to_reg,
  output logic [2:0]                  state,
  output logic                        busy,
  output logic [CNT_W-1:0]            retired
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    BRANCH = 3'd6
  } state_t;

  localparam logic [2:0] OP_LW = 3'd0;
  localparam logic [2:0] OP_SW = 3'd1;

  state_t            state_reg;
  state_t            state_next;
  logic [CNT_W-1:0]  retired_reg;
  logic              retire;
  logic              mem_req_next;
  logic              mem_we_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      retired_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (retire)
        retired_reg <= retired_reg + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    state_next   = IDLE;
    retire       = 1'b0;
    mem_req_next = 1'b0;
    mem_we_next  = 1'b0;
    iord         = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    alu_op       = 2'b00;
    alu_src_b    = 2'b00;
    reg_write    = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;

    case (state_reg)
      IDLE: state_next = start ? FETCH : IDLE;

      FETCH: begin
        mem_req_next = 1'b1;
        alu_src_b    = 2'b01;
        state_next   = FETCH;
        if (bus.mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = DECODE;
        end
      end

      DECODE: state_next = (opcode[2:1] == 2'b01) ? BRANCH : EXEC;

      EXEC: begin
        if (opcode[2:1] == 2'b00) begin
          alu_src_b  = 2'b10;
          state_next = MEM;
        end else begin
          alu_op     = opcode[1:0];
          state_next = WB;
        end
      end

      MEM: begin
        mem_req_next = 1'b1;
        mem_we_next  = (opcode == OP_SW);
        iord         = 1'b1;
        state_next   = MEM;
        if (bus.mem_ready) begin
          if (opcode == OP_SW)
            retire = 1'b1;
          else
            state_next = WB;
        end
      end

      WB: begin
        reg_write  = 1'b1;
        reg_dst    = opcode[2];
        mem_to_reg = (opcode == OP_LW);
        retire     = 1'b1;
      end

      BRANCH: begin
        alu_op   = 2'b01;
        pc_src   = 1'b1;
        pc_write = opcode[0] ? lt : zero;
        retire   = 1'b1;
      end

      default: state_next = IDLE;
    endcase

    // Every retiring state shares the same instruction-boundary exit.
    if (retire)
      state_next = halt ? IDLE : FETCH;
  end

  assign bus.mem_req = mem_req_next;
  assign bus.mem_we  = mem_we_next;
  assign state       = state_reg;
  assign busy        = (state_reg != IDLE);
  assign retired     = retired_reg;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed table-driven bench for multicycle_control_unit (2-bit counter to exercise wrap).
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       halt = 1'b0;
  logic [2:0] opcode = 3'd0;
  logic       zero = 1'b0;
  logic       lt = 1'b0;
  logic       iord, ir_write, pc_write, pc_src, reg_write, reg_dst, mem_to_reg, busy;
  logic [1:0] alu_op, alu_src_b, retired;
  logic [2:0] state;

  multicycle_control_unit_if bus ();

  multicycle_control_unit #(.CNT_W(2)) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .opcode(opcode),
    .zero(zero), .lt(lt), .bus(bus), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_op(alu_op), .alu_src_b(alu_src_b),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .state(state), .busy(busy), .retired(retired)
  );

  always #5 clk = ~clk;

  // Control word order: mem_req mem_we iord ir_write pc_write pc_src alu_op alu_src_b reg_write reg_dst mem_to_reg
  localparam logic [12:0] C_NONE   = 13'b0_0_0_0_0_0_00_00_0_0_0;
  localparam logic [12:0] C_F_WAIT = 13'b1_0_0_0_0_0_00_01_0_0_0;
  localparam logic [12:0] C_F_RDY  = 13'b1_0_0_1_1_0_00_01_0_0_0;
  localparam logic [12:0] C_EX_MEM = 13'b0_0_0_0_0_0_00_10_0_0_0;
  localparam logic [12:0] C_EX_SUB = 13'b0_0_0_0_0_0_01_00_0_0_0;
  localparam logic [12:0] C_EX_AND = 13'b0_0_0_0_0_0_10_00_0_0_0;
  localparam logic [12:0] C_EX_OR  = 13'b0_0_0_0_0_0_11_00_0_0_0;
  localparam logic [12:0] C_MEM_LW = 13'b1_0_1_0_0_0_00_00_0_0_0;
  localparam logic [12:0] C_MEM_SW = 13'b1_1_1_0_0_0_00_00_0_0_0;
  localparam logic [12:0] C_WB_ALU = 13'b0_0_0_0_0_0_00_00_1_1_0;
  localparam logic [12:0] C_WB_LW  = 13'b0_0_0_0_0_0_00_00_1_0_1;
  localparam logic [12:0] C_BR_T   = 13'b0_0_0_0_1_1_01_00_0_0_0;
  localparam logic [12:0] C_BR_NT  = 13'b0_0_0_0_0_1_01_00_0_0_0;

  typedef struct {
    logic        start;
    logic        halt;
    logic [2:0]  opcode;
    logic        zero;
    logic        lt;
    logic        mem_ready;
    logic [2:0]  st;
    logic [12:0] ctrl;
    logic [1:0]  ret;
  } vec_t;

  vec_t vq[$];
  int total = 0;
  int bad = 0;

  task automatic add(input logic s, input logic h, input logic [2:0] op, input logic z,
                     input logic l, input logic mr, input logic [2:0] st,
                     input logic [12:0] ctrl, input logic [1:0] ret);
    vec_t v;
    v.start = s; v.halt = h; v.opcode = op; v.zero = z; v.lt = l; v.mem_ready = mr;
    v.st = st; v.ctrl = ctrl; v.ret = ret;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [12:0] ctrl_word();
    return {bus.mem_req, bus.mem_we, iord, ir_write, pc_write, pc_src,
            alu_op, alu_src_b, reg_write, reg_dst, mem_to_reg};
  endfunction

  initial begin
    bus.mem_ready = 1'b0;

    //   start halt op  z  l  mr  state ctrl      retired
    add(0, 0, 3'd0, 0, 0, 1, 3'd0, C_NONE,   2'd0);  // idle, no start
    add(1, 0, 3'd0, 0, 0, 1, 3'd0, C_NONE,   2'd0);  // start sampled
    add(0, 0, 3'd4, 0, 0, 1, 3'd1, C_F_RDY,  2'd0);  // ADD
    add(0, 0, 3'd4, 0, 0, 1, 3'd2, C_NONE,   2'd0);
    add(0, 0, 3'd4, 0, 0, 1, 3'd3, C_NONE,   2'd0);
    add(0, 0, 3'd4, 0, 0, 1, 3'd5, C_WB_ALU, 2'd0);
    add(0, 0, 3'd0, 0, 0, 1, 3'd1, C_F_RDY,  2'd1);  // LW with 3-cycle stall
    add(0, 0, 3'd0, 0, 0, 1, 3'd2, C_NONE,   2'd1);
    add(0, 0, 3'd0, 0, 0, 1, 3'd3, C_EX_MEM, 2'd1);
    add(0, 0, 3'd0, 0, 0, 0, 3'd4, C_MEM_LW, 2'd1);
    add(0, 0, 3'd0, 0, 0, 0, 3'd4, C_MEM_LW, 2'd1);
    add(0, 0, 3'd0, 0, 0, 0, 3'd4, C_MEM_LW, 2'd1);
    add(0, 0, 3'd0, 0, 0, 1, 3'd4, C_MEM_LW, 2'd1);
    add(0, 0, 3'd0, 0, 0, 1, 3'd5, C_WB_LW,  2'd1);
    add(0, 0, 3'd1, 0, 0, 1, 3'd1, C_F_RDY,  2'd2);  // SW
    add(0, 0, 3'd1, 0, 0, 1, 3'd2, C_NONE,   2'd2);
    add(0, 0, 3'd1, 0, 0, 1, 3'd3, C_EX_MEM, 2'd2);
    add(0, 0, 3'd1, 0, 0, 1, 3'd4, C_MEM_SW, 2'd2);
    add(0, 0, 3'd2, 1, 0, 1, 3'd1, C_F_RDY,  2'd3);  // BEQ taken
    add(0, 0, 3'd2, 1, 0, 1, 3'd2, C_NONE,   2'd3);
    add(0, 0, 3'd2, 1, 0, 1, 3'd6, C_BR_T,   2'd3);
    add(0, 0, 3'd3, 1, 0, 1, 3'd1, C_F_RDY,  2'd0);  // BLT not taken, counter wrapped
    add(0, 0, 3'd3, 1, 0, 1, 3'd2, C_NONE,   2'd0);
    add(0, 0, 3'd3, 1, 0, 1, 3'd6, C_BR_NT,  2'd0);
    add(0, 0, 3'd5, 0, 0, 1, 3'd1, C_F_RDY,  2'd1);  // SUB, halt in WB
    add(0, 0, 3'd5, 0, 0, 1, 3'd2, C_NONE,   2'd1);
    add(0, 0, 3'd5, 0, 0, 1, 3'd3, C_EX_SUB, 2'd1);
    add(0, 1, 3'd5, 0, 0, 1, 3'd5, C_WB_ALU, 2'd1);
    add(0, 0, 3'd0, 0, 0, 1, 3'd0, C_NONE,   2'd2);
    add(0, 0, 3'd0, 0, 0, 1, 3'd0, C_NONE,   2'd2);
    add(1, 1, 3'd0, 0, 0, 1, 3'd0, C_NONE,   2'd2);  // start+halt together
    add(0, 0, 3'd6, 0, 0, 0, 3'd1, C_F_WAIT, 2'd2);  // AND with fetch stall
    add(0, 0, 3'd6, 0, 0, 1, 3'd1, C_F_RDY,  2'd2);
    add(0, 0, 3'd6, 0, 0, 1, 3'd2, C_NONE,   2'd2);
    add(0, 0, 3'd6, 0, 0, 1, 3'd3, C_EX_AND, 2'd2);
    add(0, 0, 3'd6, 0, 0, 1, 3'd5, C_WB_ALU, 2'd2);
    add(0, 0, 3'd7, 0, 0, 1, 3'd1, C_F_RDY,  2'd3);  // OR, halt in WB
    add(0, 0, 3'd7, 0, 0, 1, 3'd2, C_NONE,   2'd3);
    add(0, 0, 3'd7, 0, 0, 1, 3'd3, C_EX_OR,  2'd3);
    add(0, 1, 3'd7, 0, 0, 1, 3'd5, C_WB_ALU, 2'd3);
    add(0, 0, 3'd0, 0, 0, 1, 3'd0, C_NONE,   2'd0);

    // Reset state before any clock edge
    #1;
    check("reset_state", 32'(state), 32'd0);
    check("reset_ctrl", 32'(ctrl_word()), 32'(C_NONE));
    check("reset_retired", 32'(retired), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      start = vq[i].start; halt = vq[i].halt; opcode = vq[i].opcode;
      zero = vq[i].zero; lt = vq[i].lt; bus.mem_ready = vq[i].mem_ready;
      #1;
      check($sformatf("v%0d_state", i), 32'(state), 32'(vq[i].st));
      check($sformatf("v%0d_ctrl", i), 32'(ctrl_word()), 32'(vq[i].ctrl));
      check($sformatf("v%0d_busy", i), 32'(busy), 32'(vq[i].st != 3'd0));
      check($sformatf("v%0d_retired", i), 32'(retired), 32'(vq[i].ret));
      $display("vec %0d: op=%0d state=%0d ctrl=%b retired=%0d", i, opcode, state, ctrl_word(), retired);
      @(negedge clk);
    end

    // Reset mid-MEM: ADD retires, then LW stalls in MEM and rst hits mid-cycle
    start = 1'b1; halt = 1'b0; opcode = 3'd4; bus.mem_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    opcode = 3'd0;
    check("rstseq_fetch_state", 32'(state), 32'd1);
    check("rstseq_retired_before", 32'(retired), 32'd1);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rstseq_in_mem", 32'(state), 32'd4);
    check("rstseq_mem_req_held", 32'(bus.mem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_state", 32'(state), 32'd0);
    check("async_rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("async_rst_retired", 32'(retired), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    $display("reset mid-MEM: state=%0d mem_req=%0d retired=%0d", state, bus.mem_req, retired);
    @(negedge clk);
    rst = 1'b0;
    bus.mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("post_rst_idle%0d", k), 32'(state), 32'd0);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("post_rst_start_fetch", 32'(state), 32'd1);
    $display("restart after reset: state=%0d", state);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Moore/Mealy finite-state controller that sequences the multi-cycle datapath through fetch, decode, execute, memory and write-back for the eight-opcode ISA: LW=0, SW=1, BEQ=2, BLT=3, ADD=4, SUB=5, AND=6, OR=7. It takes the opcode from the instruction decoder and the ALU flags, and handshakes with the unified instruction/data memory. It drives every datapath mux-select and write-enable, and keeps a retired-instruction counter.

## Interface
- CNT_W, 16, width of retired-instruction counter
- clk  in  1  system clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  leave IDLE and begin fetching
- halt  in  1  stop at next instruction boundary
- opcode  in  3  opcode field from decoder (instruction bits [31:29])
- zero  in  1  ALU result == 0
- lt  in  1  ALU signed rs < rt
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  1 = write (SW only)
- iord  out  1  address source: 0 = PC, 1 = ALU result register
- ir_write  out  1  load instruction register
- pc_write  out  1  load PC
- pc_src  out  1  0 = PC+1, 1 = branch target (PC + sign-extended addr)
- alu_op  out  2  00 add, 01 sub, 10 and, 11 or
- alu_src_b  out  2  00 = rt, 01 = constant 1, 10 = sign-extended addr
- reg_write  out  1  register-file write enable
- reg_dst  out  1  write register: 0 = rt (reg1), 1 = rd (reg2)
- mem_to_reg  out  1  write data: 0 = ALU result, 1 = memory data
- state  out  3  current state encoding, for debug
- busy  out  1  state != IDLE
- retired  out  CNT_W  count of completed instructions

## Operation
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, BRANCH=6. Code 7 is illegal and returns to IDLE on the next edge.
- All outputs default to 0 unless they are listed for the current state.
- **IDLE**
  - start=1 → FETCH.
- **FETCH**
  - Drives mem_req=1, iord=0, alu_src_b=01, alu_op=00.
  - While mem_ready=0: stay in FETCH.
  - When mem_ready=1 (Mealy): ir_write=1, pc_write=1, pc_src=0, then → DECODE.
- **DECODE**
  - No enables asserted.
  - Next state by opcode: 0–1 → EXEC; 2–3 → BRANCH; 4–7 → EXEC.
- **EXEC**
  - LW/SW: alu_src_b=10, alu_op=00, then → MEM.
  - ADD–OR: alu_src_b=00, alu_op=opcode[1:0], then → WB.
- **MEM**
  - Drives mem_req=1, iord=1, mem_we=(opcode==SW).
  - While mem_ready=0: stay in MEM.
  - When mem_ready=1: LW → WB; SW retires.
- **WB**
  - Drives reg_write=1, reg_dst=(opcode≥4), mem_to_reg=(opcode==LW).
  - Instruction retires.
- **BRANCH**
  - Drives alu_src_b=00, alu_op=01.
  - taken = zero for BEQ, lt for BLT.
  - pc_write=taken, pc_src=1 (Mealy).
  - Instruction retires.
- **Retire**
  - retired increments by 1, modulo 2^CNT_W (wraps to 0).
  - Next state = IDLE if halt=1 in that cycle, else FETCH.
- opcode is sampled combinationally and must be held stable by the IR from DECODE through retirement.

## Timing
- Reset (async, takes effect immediately, including mid-operation):
  - state=IDLE.
  - All control outputs 0, busy=0, retired=0.
  - An in-flight memory request is abandoned: mem_req drops without waiting for mem_ready.
- Minimum cycle counts from FETCH entry, with mem_ready=1 each memory cycle:
  - LW: 5
  - SW: 4
  - ADD/SUB/AND/OR: 4
  - BEQ/BLT: 3
- Each cycle with mem_ready=0 in FETCH or MEM adds one cycle.
- The first FETCH follows IDLE by one cycle after start is sampled high.
- retired updates on the clock edge that leaves the retiring state.
- If start and halt are both high in IDLE, the controller still enters FETCH; halt is honoured only at retirement.
- mem_ready outside FETCH/MEM is ignored.

## Test plan
- **Reset mid-MEM:** LW with mem_ready=0, assert rst while in MEM → state=0, mem_req=0 and retired=0 without a clock edge; after release, stays IDLE until start.
- **ADD:** opcode=4, mem_ready=1 → states 1,2,3,5,1.
  - EXEC: alu_op=00, alu_src_b=00.
  - WB: reg_write=1, reg_dst=1, mem_to_reg=0.
  - retired=1 after 4 cycles.
- **LW with memory stall:** opcode=0, mem_ready low for 3 MEM cycles.
  - mem_req=1, iord=1, mem_we=0 held for 4 cycles.
  - WB: mem_to_reg=1, reg_dst=0.
  - Instruction takes 8 cycles.
- **SW:** opcode=1 → mem_we=1 in MEM, WB skipped, reg_write never 1, back to FETCH after 4 cycles.
- **Branches:**
  - BEQ with zero=1 → pc_write=1, pc_src=1 in BRANCH.
  - BLT with lt=0 → pc_write=0.
  - Both take 3 cycles and both increment retired.
- **Halt and counter wrap:** halt=1 during SUB's WB → IDLE next cycle, busy=0. With CNT_W=2, four retired instructions → retired=0.
